// File: rtl/types.sv
// Shared control encodings between the decoder, ALU and core sequencer.
package types;
  typedef enum logic [3:0] {
    ALU_FUNC_UNKNOWN = 4'd0, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_EQ
  } alu_func_t;

  typedef enum logic [2:0] {
    BRANCH_NONE, BRANCH_TRUE, BRANCH_FALSE, BRANCH_ALWAYS, BRANCH_INDIRECT
  } branch_t;

  typedef enum logic [1:0] {
    WRITEBACK_NONE, WRITEBACK_ALU, WRITEBACK_PC
  } writeback_t;

  typedef struct packed {
    alu_func_t  alu_func;
    logic       use_imm;
    branch_t    branch;
    writeback_t writeback;
  } control_t;
endpackage

// File: rtl/core_sequencer_if.sv
// Instruction-memory fetch port: req/ready request phase, rvalid/rdata response phase.
interface core_sequencer_if #(parameter int XLEN = 64);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rvalid, imem_rdata);
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the RV64 integer core.
module core_sequencer
  import types::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  core_sequencer_if.master  imem,
  output logic [31:0]       instr,
  input  control_t          ctrl,
  input  logic              ctrl_valid,
  input  logic [XLEN-1:0]   alu_result,
  output alu_func_t         alu_func,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   imm,
  output logic              rf_we,
  output logic [XLEN-1:0]   rf_wdata,
  output logic [XLEN-1:0]   pc,
  output logic              retire,
  output logic              halted
);
  typedef enum logic [2:0] {
    BOOT, FETCH_REQ, FETCH_WAIT, DECODE, EXECUTE, WRITEBACK, HALT
  } state_t;

  state_t          state, state_n;
  control_t        ctrl_q;
  logic [XLEN-1:0] pc_plus4, pc_imm, ind_sum;
  logic [XLEN-1:0] next_pc, next_pc_q, wdata, wdata_q;
  logic            unused_use_imm;

  assign pc_plus4       = pc + XLEN'(4);
  assign pc_imm         = pc + imm;
  assign ind_sum        = rs1_data + imm;
  assign unused_use_imm = ctrl_q.use_imm;
  assign imem.imem_addr = pc;
  assign rf_wdata       = wdata_q;

  // Branch target and writeback value resolve from the latched control word.
  always_comb begin
    next_pc = pc_plus4;
    wdata   = '0;
    case (ctrl_q.branch)
      BRANCH_TRUE:     if (alu_result != '0) next_pc = pc_imm;
      BRANCH_FALSE:    if (alu_result == '0) next_pc = pc_imm;
      BRANCH_ALWAYS:   next_pc = pc_imm;
      BRANCH_INDIRECT: next_pc = {ind_sum[XLEN-1:1], 1'b0};
      default:         next_pc = pc_plus4;
    endcase
    case (ctrl_q.writeback)
      WRITEBACK_ALU: wdata = alu_result;
      WRITEBACK_PC:  wdata = pc_plus4;
      default:       wdata = '0;
    endcase
  end

  always_comb begin
    state_n       = state;
    imem.imem_req = 1'b0;
    rf_we         = 1'b0;
    retire        = 1'b0;
    halted        = 1'b0;
    alu_func      = ALU_FUNC_UNKNOWN;
    case (state)
      BOOT:       state_n = FETCH_REQ;
      FETCH_REQ: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ready) state_n = FETCH_WAIT;
      end
      FETCH_WAIT: if (imem.imem_rvalid) state_n = DECODE;
      DECODE:     state_n = ctrl_valid ? EXECUTE : HALT;
      EXECUTE: begin
        alu_func = ctrl_q.alu_func;
        // A misaligned target stops the core before any architectural update.
        state_n  = (next_pc[1:0] != 2'b00) ? HALT : WRITEBACK;
      end
      WRITEBACK: begin
        rf_we   = (ctrl_q.writeback != WRITEBACK_NONE);
        retire  = 1'b1;
        state_n = FETCH_REQ;
      end
      HALT:       halted = 1'b1;
      default:    state_n = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      instr     <= '0;
      ctrl_q    <= '0;
      next_pc_q <= '0;
      wdata_q   <= '0;
    end else begin
      state <= state_n;
      if (state == FETCH_WAIT && imem.imem_rvalid) instr <= imem.imem_rdata;
      if (state == DECODE && ctrl_valid) ctrl_q <= ctrl;
      if (state == EXECUTE) begin
        next_pc_q <= next_pc;
        wdata_q   <= wdata;
      end
      if (state == WRITEBACK) pc <= next_pc_q;
    end
  end
endmodule

// File: tb/tb_core_sequencer.sv
// Scenario bench for core_sequencer: plays instruction memory and decoder, checks against an ISA-level model.
module tb_core_sequencer;
  import types::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  control_t    ctrl;
  logic        ctrl_valid;
  logic [63:0] alu_result, rs1_data, imm, rf_wdata, pc;
  alu_func_t   alu_func;
  logic        rf_we, retire, halted;

  core_sequencer_if #(.XLEN(64)) imem ();

  core_sequencer #(.XLEN(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n), .imem(imem), .instr(instr), .ctrl(ctrl),
    .ctrl_valid(ctrl_valid), .alu_result(alu_result), .alu_func(alu_func),
    .rs1_data(rs1_data), .imm(imm), .rf_we(rf_we), .rf_wdata(rf_wdata),
    .pc(pc), .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] m_pc = 64'h0;

  typedef struct {
    int          cyc, n_req, n_we, n_ret, af_cnt;
    logic [63:0] wdata, pc_after;
    logic [31:0] ins;
    alu_func_t   af_val;
    logic        hlt, addr_bad, req_bad, tout;
  } obs_t;

  function automatic control_t mkc(alu_func_t f, branch_t b, writeback_t w);
    control_t x;
    x.alu_func = f; x.use_imm = 1'b1; x.branch = b; x.writeback = w;
    return x;
  endfunction

  // Architectural effect of one instruction at PC p.
  function automatic void model(input logic [63:0] p, input control_t c, input logic cv,
                                input logic [63:0] alu, r1, im,
                                output logic [63:0] npc, output logic [63:0] wd,
                                output logic we, output logic hlt);
    logic [63:0] tgt;
    npc = p; wd = 64'h0; we = 1'b0; hlt = !cv;
    if (cv) begin
      case (c.branch)
        BRANCH_NONE:   tgt = p + 4;
        BRANCH_TRUE:   tgt = (alu != 0) ? p + im : p + 4;
        BRANCH_FALSE:  tgt = (alu == 0) ? p + im : p + 4;
        BRANCH_ALWAYS: tgt = p + im;
        default:       tgt = (r1 + im) & ~64'd1;
      endcase
      wd  = (c.writeback == WRITEBACK_PC) ? p + 4 : alu;
      hlt = (tgt % 4) != 0;
      we  = !hlt && (c.writeback != WRITEBACK_NONE);
      npc = hlt ? p : tgt;
    end
  endfunction

  // Acts as memory and decoder for one instruction; returns what the DUT did.
  task automatic run_instr(input logic [31:0] word, input control_t c, input logic cv,
                           input logic [63:0] alu, r1, im, input int rw, vw,
                           input logic noise, input int abort_at, output obs_t o);
    int phase = 0, nreq = 0, nwait = 0;
    o.cyc = 0; o.n_req = 0; o.n_we = 0; o.n_ret = 0; o.af_cnt = 0;
    o.wdata = 0; o.pc_after = 0; o.ins = 0; o.af_val = ALU_FUNC_UNKNOWN;
    o.hlt = 0; o.addr_bad = 0; o.req_bad = 0; o.tout = 1;
    ctrl = c; ctrl_valid = cv; alu_result = alu; rs1_data = r1; imm = im;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      o.cyc++;
      if (imem.imem_req) o.n_req++;
      if (imem.imem_req && imem.imem_addr !== m_pc) o.addr_bad = 1;
      if (imem.imem_req && phase != 0) o.req_bad = 1;
      if (rf_we) begin o.n_we++; o.wdata = rf_wdata; end
      if (retire) o.n_ret++;
      if (alu_func != ALU_FUNC_UNKNOWN) begin o.af_cnt++; o.af_val = alu_func; end
      o.hlt = halted; o.ins = instr;
      imem.imem_ready = 1'b0; imem.imem_rvalid = noise; imem.imem_rdata = ~word;
      if (phase == 0 && imem.imem_req) begin
        nreq++;
        if (nreq > rw) begin imem.imem_ready = 1'b1; phase = 1; end
      end else if (phase == 1) begin
        nwait++;
        imem.imem_rvalid = 1'b0;
        if (nwait > vw) begin imem.imem_rvalid = 1'b1; imem.imem_rdata = word; phase = 2; end
      end
      if (retire || halted || o.cyc == abort_at) begin o.tout = 0; break; end
    end
    imem.imem_ready = 1'b0; imem.imem_rvalid = 1'b0;
    if (abort_at == 0) begin @(posedge clk); #1; o.pc_after = pc; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem.imem_ready = 1'b0; imem.imem_rvalid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; m_pc = 64'h0;
  endtask

  task automatic goto_pc(input logic [63:0] target);
    obs_t o;
    run_instr(32'h0000006F, mkc(ALU_ADD, BRANCH_ALWAYS, WRITEBACK_NONE), 1'b1, 0, 0,
              target - m_pc, 0, 0, 1'b0, 0, o);
    m_pc = target;
    vectors++; if (o.pc_after !== target) begin miscompares++; $display("FAIL goto_pc got %h want %h", o.pc_after, target); end
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    vectors++; if (imem.imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got %b want 0", imem.imem_req); end
    vectors++; if (pc !== 64'h0 || imem.imem_addr !== 64'h0) begin miscompares++; $display("FAIL rst_pc got %h/%h want 0", pc, imem.imem_addr); end
    vectors++; if (instr !== 32'h0) begin miscompares++; $display("FAIL rst_instr got %h want 0", instr); end
    vectors++; if ({rf_we, retire, halted} !== 3'b000) begin miscompares++; $display("FAIL rst_strobes got %b want 000", {rf_we, retire, halted}); end
    vectors++; if (alu_func !== ALU_FUNC_UNKNOWN) begin miscompares++; $display("FAIL rst_alu_func got %0d want 0", alu_func); end
    rst_n = 1'b1; #1;
    vectors++; if (imem.imem_req !== 1'b0) begin miscompares++; $display("FAIL boot_req got %b want 0", imem.imem_req); end
  endtask

  task automatic test_addi();
    obs_t o;
    run_instr(32'h00500093, mkc(ALU_ADD, BRANCH_NONE, WRITEBACK_ALU), 1'b1, 64'd5, 0, 64'd5, 0, 0, 1'b1, 0, o);
    vectors++; if (o.addr_bad !== 1'b0) begin miscompares++; $display("FAIL addi_addr got bad want imem_addr=0"); end
    vectors++; if (o.cyc !== 5) begin miscompares++; $display("FAIL addi_cycles got %0d want 5", o.cyc); end
    vectors++; if (o.n_we !== 1 || o.wdata !== 64'd5) begin miscompares++; $display("FAIL addi_write got %0d/%h want 1/5", o.n_we, o.wdata); end
    vectors++; if (o.n_ret !== 1) begin miscompares++; $display("FAIL addi_retire got %0d want 1", o.n_ret); end
    vectors++; if (o.pc_after !== 64'h4) begin miscompares++; $display("FAIL addi_pc got %h want 4", o.pc_after); end
    vectors++; if (o.ins !== 32'h00500093) begin miscompares++; $display("FAIL addi_instr got %h want 00500093", o.ins); end
    vectors++; if (o.af_cnt !== 1 || o.af_val !== ALU_ADD) begin miscompares++; $display("FAIL addi_alu_func got %0d/%0d want 1/%0d", o.af_cnt, o.af_val, ALU_ADD); end
    m_pc = 64'h4;
  endtask

  task automatic test_branch();
    obs_t o;
    goto_pc(64'h100);
    run_instr(32'hFE000CE3, mkc(ALU_EQ, BRANCH_TRUE, WRITEBACK_NONE), 1'b1, 64'd1, 0, -64'sd8, 0, 0, 1'b0, 0, o);
    vectors++; if (o.pc_after !== 64'hF8 || o.n_we !== 0) begin miscompares++; $display("FAIL beq_taken got pc=%h we=%0d want F8/0", o.pc_after, o.n_we); end
    m_pc = 64'hF8;
    goto_pc(64'h100);
    run_instr(32'hFE000CE3, mkc(ALU_EQ, BRANCH_TRUE, WRITEBACK_NONE), 1'b1, 64'd0, 0, -64'sd8, 0, 0, 1'b0, 0, o);
    vectors++; if (o.pc_after !== 64'h104 || o.n_we !== 0 || o.n_ret !== 1) begin miscompares++; $display("FAIL beq_fall got pc=%h we=%0d ret=%0d want 104/0/1", o.pc_after, o.n_we, o.n_ret); end
    m_pc = 64'h104;
  endtask

  task automatic test_jalr_aligned();
    obs_t o;
    goto_pc(64'h40);
    run_instr(32'h003080E7, mkc(ALU_ADD, BRANCH_INDIRECT, WRITEBACK_PC), 1'b1, 0, 64'h1001, 64'd3, 0, 0, 1'b0, 0, o);
    vectors++; if (o.n_we !== 1 || o.wdata !== 64'h44) begin miscompares++; $display("FAIL jalr_link got %0d/%h want 1/44", o.n_we, o.wdata); end
    vectors++; if (o.pc_after !== 64'h1004) begin miscompares++; $display("FAIL jalr_pc got %h want 1004", o.pc_after); end
    m_pc = 64'h1004;
  endtask

  task automatic test_wait_states();
    obs_t o;
    run_instr(32'h00A00113, mkc(ALU_ADD, BRANCH_NONE, WRITEBACK_ALU), 1'b1, 64'd10, 0, 64'd10, 3, 2, 1'b0, 0, o);
    vectors++; if (o.cyc !== 10 || o.n_ret !== 1) begin miscompares++; $display("FAIL wait_latency got %0d/%0d want 10/1", o.cyc, o.n_ret); end
    vectors++; if (o.n_req !== 4 || o.addr_bad || o.req_bad) begin miscompares++; $display("FAIL wait_req got n=%0d bad=%b%b want 4/00", o.n_req, o.addr_bad, o.req_bad); end
    m_pc = m_pc + 4;
  endtask

  task automatic test_random();
    obs_t o;
    control_t c;
    logic cv, we, hlt;
    logic [63:0] alu, r1, im, npc, wd;
    logic [31:0] word;
    int rw, vw;
    for (int n = 0; n < 150; n++) begin
      c = mkc(alu_func_t'(4'($urandom_range(1, 11))), branch_t'(3'($urandom_range(0, 4))),
              writeback_t'(2'($urandom_range(0, 2))));
      cv   = ($urandom_range(0, 15) != 0);
      alu  = $urandom_range(0, 1) ? 64'h0 : {$urandom, $urandom};
      r1   = {$urandom, $urandom} & (($urandom_range(0, 3) == 0) ? ~64'h0 : ~64'h3);
      im   = (64'($urandom_range(0, 255)) - 64'd128) << 2;
      if ($urandom_range(0, 7) == 0) im = im + 64'($urandom_range(1, 3));
      word = $urandom; rw = $urandom_range(0, 2); vw = $urandom_range(0, 2);
      model(m_pc, c, cv, alu, r1, im, npc, wd, we, hlt);
      run_instr(word, c, cv, alu, r1, im, rw, vw, 1'($urandom_range(0, 1)), 0, o);
      vectors++; if (o.tout || o.hlt !== hlt || o.n_ret !== int'(!hlt)) begin miscompares++; $display("FAIL rnd_end[%0d] got hlt=%b ret=%0d want hlt=%b", n, o.hlt, o.n_ret, hlt); end
      vectors++; if (o.n_we !== int'(we)) begin miscompares++; $display("FAIL rnd_we[%0d] got %0d want %0d", n, o.n_we, we); end
      if (we) begin
        vectors++; if (o.wdata !== wd) begin miscompares++; $display("FAIL rnd_wdata[%0d] got %h want %h", n, o.wdata, wd); end
      end
      vectors++; if (o.pc_after !== npc || o.addr_bad) begin miscompares++; $display("FAIL rnd_pc[%0d] got %h want %h", n, o.pc_after, npc); end
      vectors++; if (o.cyc !== (cv ? 5 : 4) + rw + vw) begin miscompares++; $display("FAIL rnd_cycles[%0d] got %0d want %0d", n, o.cyc, (cv ? 5 : 4) + rw + vw); end
      vectors++; if (o.ins !== word || o.af_cnt !== int'(cv) || o.req_bad) begin miscompares++; $display("FAIL rnd_fetch[%0d] got %h/%0d want %h/%0d", n, o.ins, o.af_cnt, word, cv); end
      if (hlt) do_reset(); else m_pc = npc;
    end
  endtask

  task automatic test_illegal();
    obs_t o;
    do_reset();
    run_instr(32'hFFFFFFFF, mkc(ALU_ADD, BRANCH_NONE, WRITEBACK_ALU), 1'b0, 64'd7, 0, 0, 0, 0, 1'b0, 0, o);
    vectors++; if (o.cyc !== 4 || o.hlt !== 1'b1) begin miscompares++; $display("FAIL illegal_halt got cyc=%0d hlt=%b want 4/1", o.cyc, o.hlt); end
    vectors++; if (o.n_we !== 0 || o.n_ret !== 0) begin miscompares++; $display("FAIL illegal_strobes got %0d/%0d want 0/0", o.n_we, o.n_ret); end
    imem.imem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++; if ({imem.imem_req, rf_we, retire, halted} !== 4'b0001) begin miscompares++; $display("FAIL halt_hold[%0d] got %b want 0001", k, {imem.imem_req, rf_we, retire, halted}); end
    end
    imem.imem_ready = 1'b0;
  endtask

  task automatic test_jalr_misaligned();
    obs_t o;
    do_reset();
    goto_pc(64'h40);
    run_instr(32'h002080E7, mkc(ALU_ADD, BRANCH_INDIRECT, WRITEBACK_PC), 1'b1, 0, 64'h1001, 64'd2, 0, 0, 1'b0, 0, o);
    vectors++; if (o.hlt !== 1'b1 || o.n_we !== 0 || o.n_ret !== 0) begin miscompares++; $display("FAIL jalr_mis got hlt=%b we=%0d ret=%0d want 1/0/0", o.hlt, o.n_we, o.n_ret); end
    vectors++; if (o.pc_after !== 64'h40 || halted !== 1'b1) begin miscompares++; $display("FAIL jalr_mis_pc got %h want 40", o.pc_after); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    do_reset();
    goto_pc(64'h200);
    run_instr(32'h00100093, mkc(ALU_ADD, BRANCH_NONE, WRITEBACK_ALU), 1'b1, 64'd1, 0, 64'd1, 0, 0, 1'b0, 4, o);
    vectors++; if (o.af_cnt !== 1) begin miscompares++; $display("FAIL mid_in_execute got %0d want 1", o.af_cnt); end
    #1 rst_n = 1'b0; #1;
    vectors++; if ({imem.imem_req, rf_we, retire, halted} !== 4'b0000) begin miscompares++; $display("FAIL mid_strobes got %b want 0000", {imem.imem_req, rf_we, retire, halted}); end
    vectors++; if (pc !== 64'h0 || instr !== 32'h0 || alu_func !== ALU_FUNC_UNKNOWN) begin miscompares++; $display("FAIL mid_state got pc=%h instr=%h af=%0d want 0/0/0", pc, instr, alu_func); end
    @(negedge clk);
    rst_n = 1'b1; m_pc = 64'h0; #1;
    vectors++; if (imem.imem_req !== 1'b0) begin miscompares++; $display("FAIL mid_boot got %b want 0", imem.imem_req); end
    run_instr(32'h00500093, mkc(ALU_ADD, BRANCH_NONE, WRITEBACK_ALU), 1'b1, 64'd5, 0, 64'd5, 0, 0, 1'b0, 0, o);
    vectors++; if (o.addr_bad || o.cyc !== 5 || o.pc_after !== 64'h4) begin miscompares++; $display("FAIL mid_refetch got bad=%b cyc=%0d pc=%h want 0/5/4", o.addr_bad, o.cyc, o.pc_after); end
  endtask

  initial begin
    rst_n = 1'b0; ctrl = '0; ctrl_valid = 1'b0; alu_result = 0; rs1_data = 0; imm = 0;
    imem.imem_ready = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = 32'h0;
    test_reset();
    test_addi();
    test_branch();
    test_jalr_aligned();
    test_wait_states();
    test_random();
    test_illegal();
    test_jalr_misaligned();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
